// File: rtl/mcrc_stream_if.sv
// Streaming bus for mcrc_stream: framed beat input plus registered result output.
// The master drives beats and consumes results; the slave is the CRC engine.
interface mcrc_stream_if #(
   parameter int unsigned MAX_WIDTH = 32,
   parameter int unsigned DW        = 8
);
   logic                   s_valid;
   logic                   s_ready;
   logic [DW-1:0]          s_data;
   logic                   s_last;
   logic [$clog2(DW):0]    s_nbits;
   logic [MAX_WIDTH-1:0]   s_chk;
   logic                   s_abort;
   logic                   m_valid;
   logic                   m_ready;
   logic [MAX_WIDTH-1:0]   m_crc;
   logic                   m_match;

   modport master (
      output s_valid, s_data, s_last, s_nbits, s_chk, s_abort, m_ready,
      input  s_ready, m_valid, m_crc, m_match
   );

   modport slave (
      input  s_valid, s_data, s_last, s_nbits, s_chk, s_abort, m_ready,
      output s_ready, m_valid, m_crc, m_match
   );
endinterface

// File: rtl/mcrc_stream.sv
// Runtime-configurable CRC engine. Each accepted beat applies up to DW Galois bit steps
// in one cycle; the result is registered with an expected-value compare.
module mcrc_stream #(
   parameter int unsigned MAX_WIDTH = 32,
   parameter int unsigned DW        = 8
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic [MAX_WIDTH-1:0]      cfg_tap,
   input  logic [MAX_WIDTH-1:0]      cfg_ini,
   input  logic [MAX_WIDTH-1:0]      cfg_xor,
   input  logic [$clog2(MAX_WIDTH):0] cfg_msb,
   input  logic                      cfg_refin,
   input  logic                      cfg_refout,
   mcrc_stream_if.slave              bus
);
   localparam int unsigned MW = $clog2(MAX_WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [MAX_WIDTH-1:0] sum_q, sum_d;
   logic [MAX_WIDTH-1:0] tap_q, tap_d;
   logic [MAX_WIDTH-1:0] xor_q, xor_d;
   logic [MW-1:0]        msb_q, msb_d;
   logic                 refin_q, refin_d;
   logic                 refout_q, refout_d;
   logic                 m_valid_q, m_valid_d;
   logic [MAX_WIDTH-1:0] m_crc_q, m_crc_d;
   logic                 m_match_q, m_match_d;

   logic [MW-1:0]        msb_cfg, msb_e;
   logic [MAX_WIDTH-1:0] tap_e, xor_e, mask_e, top_e;
   logic                 refin_e, refout_e;
   logic [MAX_WIDTH-1:0] sum_nx, rev_full, rev, crc_nx;
   logic                 match_nx;
   logic                 accept;

   // In IDLE the live config drives the first beat; afterwards the shadow copy is used.
   always_comb begin
      msb_cfg  = (cfg_msb >= MW'(MAX_WIDTH)) ? MW'(MAX_WIDTH - 1) : cfg_msb;
      if (state_q == StIdle) begin
         msb_e    = msb_cfg;
         tap_e    = cfg_tap;
         xor_e    = cfg_xor;
         refin_e  = cfg_refin;
         refout_e = cfg_refout;
      end else begin
         msb_e    = msb_q;
         tap_e    = tap_q;
         xor_e    = xor_q;
         refin_e  = refin_q;
         refout_e = refout_q;
      end
      mask_e = '0;
      for (int j = 0; j < int'(MAX_WIDTH); j++) begin
         mask_e[j] = (j <= int'(msb_e));
      end
      top_e = mask_e ^ (mask_e >> 1);
   end

   always_comb begin
      int   nb;
      logic x;
      logic fb;
      nb = int'(bus.s_nbits);
      if (!bus.s_last || nb == 0 || nb >= int'(DW)) begin
         nb = int'(DW);
      end
      sum_nx = (state_q == StIdle) ? (cfg_ini & mask_e) : sum_q;
      x      = 1'b0;
      fb     = 1'b0;
      for (int i = 0; i < int'(DW); i++) begin
         x = refin_e ? bus.s_data[i] : bus.s_data[DW-1-i];
         if (i < nb) begin
            fb     = (|(sum_nx & top_e)) ^ x;
            sum_nx = ((sum_nx << 1) ^ (fb ? tap_e : '0)) & mask_e;
         end
      end
      // Full-width reversal, then shift the active window back down to bit 0.
      for (int j = 0; j < int'(MAX_WIDTH); j++) begin
         rev_full[j] = sum_nx[MAX_WIDTH-1-j];
      end
      rev      = rev_full >> (MW'(MAX_WIDTH - 1) - msb_e);
      crc_nx   = ((refout_e ? rev : sum_nx) ^ xor_e) & mask_e;
      match_nx = (crc_nx == (bus.s_chk & mask_e));
   end

   assign bus.s_ready = (state_q != StDone);
   assign accept      = bus.s_valid & bus.s_ready;

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      tap_d     = tap_q;
      xor_d     = xor_q;
      msb_d     = msb_q;
      refin_d   = refin_q;
      refout_d  = refout_q;
      m_valid_d = m_valid_q;
      m_crc_d   = m_crc_q;
      m_match_d = m_match_q;
      case (state_q)
         StIdle, StRun: begin
            if (bus.s_abort) begin
               state_d = StIdle;
            end else if (accept) begin
               sum_d = sum_nx;
               if (state_q == StIdle) begin
                  tap_d    = cfg_tap;
                  xor_d    = cfg_xor;
                  msb_d    = msb_cfg;
                  refin_d  = cfg_refin;
                  refout_d = cfg_refout;
               end
               if (bus.s_last) begin
                  state_d   = StDone;
                  m_valid_d = 1'b1;
                  m_crc_d   = crc_nx;
                  m_match_d = match_nx;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StDone: begin
            if (bus.m_ready) begin
               state_d   = StIdle;
               m_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= StIdle;
         sum_q     <= '0;
         tap_q     <= '0;
         xor_q     <= '0;
         msb_q     <= '0;
         refin_q   <= 1'b0;
         refout_q  <= 1'b0;
         m_valid_q <= 1'b0;
         m_crc_q   <= '0;
         m_match_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         tap_q     <= tap_d;
         xor_q     <= xor_d;
         msb_q     <= msb_d;
         refin_q   <= refin_d;
         refout_q  <= refout_d;
         m_valid_q <= m_valid_d;
         m_crc_q   <= m_crc_d;
         m_match_q <= m_match_d;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_crc   = m_crc_q;
   assign bus.m_match = m_match_q;
endmodule

// File: tb/tb_mcrc_stream.sv
// Directed bench for mcrc_stream using standard CRC catalogue check values over "123456789".
module tb_mcrc_stream;
   logic        clk;
   logic        rstb;
   logic [31:0] cfg_tap;
   logic [31:0] cfg_ini;
   logic [31:0] cfg_xor;
   logic [5:0]  cfg_msb;
   logic        cfg_refin;
   logic        cfg_refout;
   logic [7:0]  msg [9];
   int          n_checks;
   int          n_errors;

   mcrc_stream_if #(.MAX_WIDTH(32), .DW(8)) bus ();

   mcrc_stream #(.MAX_WIDTH(32), .DW(8)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .cfg_tap    (cfg_tap),
      .cfg_ini    (cfg_ini),
      .cfg_xor    (cfg_xor),
      .cfg_msb    (cfg_msb),
      .cfg_refin  (cfg_refin),
      .cfg_refout (cfg_refout),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] tap, input logic [31:0] ini, input logic [31:0] xr,
                          input logic [5:0] msb, input logic ri, input logic ro);
      cfg_tap    = tap;
      cfg_ini    = ini;
      cfg_xor    = xr;
      cfg_msb    = msb;
      cfg_refin  = ri;
      cfg_refout = ro;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic [3:0] nb,
                       input logic [31:0] chk);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_nbits = nb;
      bus.s_chk   = chk;
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = 8'h00;
   endtask

   // Sends "123456789"; gaps of (i mod (maxgap+1)) idle cycles precede beat i.
   task automatic frame9(input int maxgap, input logic [31:0] chk, input bit tapchg);
      for (int i = 0; i < 9; i++) begin
         if (maxgap > 0) begin
            repeat (i % (maxgap + 1)) tick();
         end
         if (i == 8) check("pre_last_m_valid", {31'b0, bus.m_valid}, 32'h0);
         send(msg[i], (i == 8), 4'd0, chk);
         if (tapchg && i == 0) cfg_tap = 32'hDEADBEEF;
      end
   endtask

   task automatic collect(input string tag, input logic [31:0] crc, input logic match);
      check({tag, "_m_valid"}, {31'b0, bus.m_valid}, 32'h1);
      check({tag, "_m_crc"}, bus.m_crc, crc);
      check({tag, "_m_match"}, {31'b0, bus.m_match}, {31'b0, match});
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      check({tag, "_released"}, {31'b0, bus.m_valid}, 32'h0);
      check({tag, "_s_ready"}, {31'b0, bus.s_ready}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
      rstb        = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.s_last  = 1'b0;
      bus.s_nbits = 4'd0;
      bus.s_chk   = 32'h0;
      bus.s_abort = 1'b0;
      bus.m_ready = 1'b0;
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd31, 1'b1, 1'b1);
      repeat (2) tick();
      check("rst_m_valid", {31'b0, bus.m_valid}, 32'h0);
      check("rst_m_crc", bus.m_crc, 32'h0);
      check("rst_m_match", {31'b0, bus.m_match}, 32'h0);
      rstb = 1'b1;
      tick();
      check("rst_s_ready", {31'b0, bus.s_ready}, 32'h1);

      // CRC-32
      frame9(0, 32'hCBF43926, 1'b0);
      collect("crc32", 32'hCBF43926, 1'b1);

      // CRC-16/CCITT-FALSE, matching and non-matching expected value
      set_cfg(32'h1021, 32'hFFFF, 32'h0, 6'd15, 1'b0, 1'b0);
      frame9(0, 32'h29B1, 1'b0);
      collect("crc16_ok", 32'h29B1, 1'b1);
      frame9(0, 32'h29B0, 1'b0);
      collect("crc16_bad", 32'h29B1, 1'b0);

      // CRC-8 with valid gaps, then a 1-bit partial beat
      set_cfg(32'h07, 32'h0, 32'h0, 6'd7, 1'b0, 1'b0);
      frame9(3, 32'h0, 1'b0);
      collect("crc8_gaps", 32'hF4, 1'b0);
      send(8'h80, 1'b1, 4'd1, 32'h0);
      collect("crc8_nbits1", 32'h07, 1'b0);

      // W=1 parity: 0xA7 has five ones
      set_cfg(32'h1, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
      send(8'hA7, 1'b1, 4'd0, 32'hFFFFFFFF);
      collect("parity", 32'h1, 1'b1);

      // Backpressure, with cfg_msb above range clamping to 31
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd40, 1'b1, 1'b1);
      frame9(0, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check("bp_m_valid", {31'b0, bus.m_valid}, 32'h1);
         check("bp_m_crc", bus.m_crc, 32'hCBF43926);
         check("bp_s_ready", {31'b0, bus.s_ready}, 32'h0);
         tick();
      end
      collect("bp", 32'hCBF43926, 1'b0);

      // Config latch: cfg_tap corrupted after the first beat
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd31, 1'b1, 1'b1);
      frame9(0, 32'hCBF43926, 1'b1);
      collect("cfg_latch", 32'hCBF43926, 1'b1);

      // Abort after beat 4 with a beat presented alongside, then a clean frame
      set_cfg(32'h1021, 32'hFFFF, 32'h0, 6'd15, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(msg[i], 1'b0, 4'd0, 32'h0);
      bus.s_abort = 1'b1;
      send(msg[4], 1'b1, 4'd0, 32'h0);
      bus.s_abort = 1'b0;
      check("abort_m_valid", {31'b0, bus.m_valid}, 32'h0);
      check("abort_s_ready", {31'b0, bus.s_ready}, 32'h1);
      tick();
      check("abort_m_valid2", {31'b0, bus.m_valid}, 32'h0);
      frame9(0, 32'h29B1, 1'b0);
      collect("post_abort", 32'h29B1, 1'b1);

      // Asynchronous reset mid-frame
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd31, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send(msg[i], 1'b0, 4'd0, 32'h0);
      #2;
      rstb = 1'b0;
      #1;
      check("midrst_m_valid", {31'b0, bus.m_valid}, 32'h0);
      check("midrst_m_crc", bus.m_crc, 32'h0);
      check("midrst_m_match", {31'b0, bus.m_match}, 32'h0);
      tick();
      rstb = 1'b1;
      tick();
      check("midrst_s_ready", {31'b0, bus.s_ready}, 32'h1);
      frame9(0, 32'hCBF43926, 1'b0);
      collect("post_rst", 32'hCBF43926, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
